// File: rtl/dual_port_ram_pkg.sv
// Shared types, constants and the byte-lane merge helper for the dual-port byte-enable RAM.
package dual_port_ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } init_state_e;

    localparam int COLL_CNT_WIDTH = 16;
    localparam int MERGE_MAX_W    = 256;

    typedef logic [MERGE_MAX_W-1:0] merge_word_t;

    // Callers zero-extend into merge_word_t and truncate the result back to their word width.
    function automatic merge_word_t byte_merge(
        input merge_word_t old_word,
        input merge_word_t new_word,
        input merge_word_t be,
        input int          byte_width
    );
        merge_word_t res;
        res = old_word;
        for (int i = 0; i < MERGE_MAX_W; i++) begin
            if (be[i / byte_width]) begin
                res[i] = new_word[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dual_port_ram_init.sv
// Post-reset clear sequencer: zeroes one word per cycle, then raises ready.
module dual_port_ram_init
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    init_state_e           state_r;
    init_state_e           state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  ready_r;
    logic                  clear_we_s;

    // State, clear address and ready registers; ready trails entry to RUN by one edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= CLEAR;
            addr_r  <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_r == RUN);
            if (state_r == CLEAR) begin
                addr_r <= addr_r + ADDR_ONE;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            CLEAR: begin
                if (addr_r == LAST_ADDR) begin
                    state_s = RUN;
                end else begin
                    state_s = CLEAR;
                end
            end
            RUN:     state_s = RUN;
            default: state_s = CLEAR;
        endcase
    end

    // Output decode.
    always_comb begin
        clear_we_s = 1'b0;
        case (state_r)
            CLEAR:   clear_we_s = 1'b1;
            RUN:     clear_we_s = 1'b0;
            default: clear_we_s = 1'b0;
        endcase
    end

    assign clear_we   = clear_we_s;
    assign clear_addr = addr_r;
    assign ready      = ready_r;

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, selectable same-port read-during-write,
// optional output stage, post-reset clear and write-collision counting.
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_NEW    = 1,
    parameter int OUT_REG    = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    output logic                          ready,
    input  logic                          en_a,
    input  logic                          en_b,
    input  logic                          we_a,
    input  logic                          we_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]         addr_a,
    input  logic [ADDR_WIDTH-1:0]         addr_b,
    input  logic [DATA_WIDTH-1:0]         data_a,
    input  logic [DATA_WIDTH-1:0]         data_b,
    output logic [DATA_WIDTH-1:0]         q_a,
    output logic [DATA_WIDTH-1:0]         q_b,
    output logic                          q_valid_a,
    output logic                          q_valid_b,
    output logic                          collision,
    output logic [COLL_CNT_WIDTH-1:0]     collision_count
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [COLL_CNT_WIDTH-1:0] COLL_MAX = '1;
    localparam logic [COLL_CNT_WIDTH-1:0] COLL_ONE = {{(COLL_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clear_we_s;
    logic [ADDR_WIDTH-1:0] clear_addr_s;
    logic                  ready_s;

    dual_port_ram_init #(.ADDR_WIDTH(ADDR_WIDTH)) u_init (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_we   (clear_we_s),
        .clear_addr (clear_addr_s),
        .ready      (ready_s)
    );

    logic acc_a_s, acc_b_s, wr_a_s, wr_b_s, overlap_s, coll_next_s;
    logic [DATA_WIDTH-1:0] old_a_s, old_b_s, merged_a_s, merged_b_s, rd_a_s, rd_b_s;

    assign acc_a_s    = ready_s & en_a;
    assign acc_b_s    = ready_s & en_b;
    assign wr_a_s     = acc_a_s & we_a;
    assign wr_b_s     = acc_b_s & we_b;
    assign overlap_s  = wr_a_s & wr_b_s & (addr_a == addr_b) & (|(be_a & be_b));
    assign old_a_s    = mem[addr_a];
    assign old_b_s    = mem[addr_b];
    assign merged_a_s = DATA_WIDTH'(byte_merge(merge_word_t'(old_a_s), merge_word_t'(data_a),
                                               merge_word_t'(be_a), BYTE_WIDTH));
    assign merged_b_s = DATA_WIDTH'(byte_merge(merge_word_t'(old_b_s), merge_word_t'(data_b),
                                               merge_word_t'(be_b), BYTE_WIDTH));

    // Same-port read-during-write selection; the other port always sees the pre-write word.
    always_comb begin
        rd_a_s = old_a_s;
        rd_b_s = old_b_s;
        if ((RDW_NEW != 0) && wr_a_s) begin
            rd_a_s = merged_a_s;
        end else begin
            rd_a_s = old_a_s;
        end
        if ((RDW_NEW != 0) && wr_b_s) begin
            rd_b_s = merged_b_s;
        end else begin
            rd_b_s = old_b_s;
        end
    end

    // Memory array writes; port B lanes are issued first so port A wins overlapping lanes.
    always_ff @(posedge clock) begin
        if (clear_we_s) begin
            mem[clear_addr_s] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b_s && be_b[i]) begin
                    mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (wr_a_s && be_a[i]) begin
                    mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] q1_a_r, q1_b_r;
    logic                  v1_a_r, v1_b_r;

    // First read stage; data holds when the port is idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q1_a_r <= '0;
            q1_b_r <= '0;
            v1_a_r <= 1'b0;
            v1_b_r <= 1'b0;
        end else begin
            v1_a_r <= acc_a_s;
            v1_b_r <= acc_b_s;
            if (acc_a_s) begin
                q1_a_r <= rd_a_s;
            end
            if (acc_b_s) begin
                q1_b_r <= rd_b_s;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2_a_r, q2_b_r;
            logic                  v2_a_r, v2_b_r, coll1_r;

            // Second output stage, with the collision flag delayed to stay aligned with q_valid.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q2_a_r  <= '0;
                    q2_b_r  <= '0;
                    v2_a_r  <= 1'b0;
                    v2_b_r  <= 1'b0;
                    coll1_r <= 1'b0;
                end else begin
                    v2_a_r  <= v1_a_r;
                    v2_b_r  <= v1_b_r;
                    coll1_r <= overlap_s;
                    if (v1_a_r) begin
                        q2_a_r <= q1_a_r;
                    end
                    if (v1_b_r) begin
                        q2_b_r <= q1_b_r;
                    end
                end
            end

            assign q_a         = q2_a_r;
            assign q_b         = q2_b_r;
            assign q_valid_a   = v2_a_r;
            assign q_valid_b   = v2_b_r;
            assign coll_next_s = coll1_r;
        end else begin : g_no_out_reg
            assign q_a         = q1_a_r;
            assign q_b         = q1_b_r;
            assign q_valid_a   = v1_a_r;
            assign q_valid_b   = v1_b_r;
            assign coll_next_s = overlap_s;
        end
    endgenerate

    logic                      collision_r;
    logic [COLL_CNT_WIDTH-1:0] coll_cnt_r;

    // Collision pulse and saturating counter, updated together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            collision_r <= 1'b0;
            coll_cnt_r  <= '0;
        end else begin
            collision_r <= coll_next_s;
            if (coll_next_s && (coll_cnt_r != COLL_MAX)) begin
                coll_cnt_r <= coll_cnt_r + COLL_ONE;
            end
        end
    end

    assign collision       = collision_r;
    assign collision_count = coll_cnt_r;
    assign ready           = ready_s;

endmodule
